// File: rtl/rom_loader.sv
// rom_loader: mirrors HPS ROM download bytes to SDRAM write ports, captures DIP bytes, stretches core reset.
// Optional define ROM_LOADER_CHECKSUM_EN adds the rom_sum output (16-bit sum of accepted ROM bytes).
module rom_loader #(
  parameter int                   NUM_PORTS   = 2,
  parameter logic [NUM_PORTS-1:0] PORT_EN     = {NUM_PORTS{1'b1}},
  parameter logic [7:0]           ROM_INDEX   = 8'd0,
  parameter logic [7:0]           DIP_INDEX   = 8'd254,
  parameter int                   DIP_BYTES   = 8,
  parameter logic [15:0]          HOLD_CYCLES = 16'hFFFF
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   soft_reset,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic                   ioctl_wait,
  output logic [NUM_PORTS-1:0]   port_req,
  input  logic [NUM_PORTS-1:0]   port_ack,
  output logic [22:0]            port_a,
  output logic [1:0]             port_ds,
  output logic [15:0]            port_d,
  output logic                   port_we,
  output logic [8*DIP_BYTES-1:0] dip_sw,
  output logic                   rom_loaded,
  output logic                   core_reset,
`ifdef ROM_LOADER_CHECKSUM_EN
  output logic [15:0]            rom_sum,
`endif
  output logic                   overrun
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  logic                 state;
  logic                 dl_q, dl_qq;
  logic                 wr_q, wr_qq;
  logic [7:0]           idx_q, idx_lat;
  logic [24:0]          addr_q;
  logic [7:0]           dout_q;
  logic [NUM_PORTS-1:0] ack_q;
  logic [15:0]          count;

  logic rom_sel;
  logic accept;
  logic acked;
  logic dip_wr;
  logic hold;

  assign rom_sel = dl_q && (idx_q == ROM_INDEX);
  assign accept  = rom_sel && wr_q && !wr_qq;
  assign acked   = ((ack_q ^ port_req) & PORT_EN) == '0;
  assign dip_wr  = wr_q && (idx_q == DIP_INDEX) && (addr_q[24:3] == 22'd0);
  assign hold    = soft_reset || !rom_loaded || ioctl_download;

  // Register the HPS strobes and SDRAM acks before any decision is made.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_q    <= 1'b0;
      dl_qq   <= 1'b0;
      wr_q    <= 1'b0;
      wr_qq   <= 1'b0;
      idx_q   <= 8'd0;
      idx_lat <= 8'd0;
      addr_q  <= 25'd0;
      dout_q  <= 8'd0;
      ack_q   <= '0;
    end else begin
      dl_q   <= ioctl_download;
      dl_qq  <= dl_q;
      wr_q   <= ioctl_wr;
      wr_qq  <= wr_q;
      idx_q  <= ioctl_index;
      addr_q <= ioctl_addr;
      dout_q <= ioctl_dout;
      ack_q  <= port_ack;
      if (dl_q) idx_lat <= idx_q;
    end
  end

  // Write FSM: issue on accepted strobe, stall HPS until all enabled acks match.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      port_req   <= '0;
      ioctl_wait <= 1'b0;
      port_a     <= 23'd0;
      port_ds    <= 2'b00;
      port_d     <= 16'd0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            port_a     <= addr_q[23:1];
            port_ds    <= {addr_q[0], ~addr_q[0]};
            port_d     <= {dout_q, dout_q};
            port_req   <= port_req ^ PORT_EN;
            ioctl_wait <= 1'b1;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept) overrun <= 1'b1;
          if (acked) begin
            ioctl_wait <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write-enable follows the registered ROM-download window.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) port_we <= 1'b0;
    else       port_we <= rom_sel;
  end

  // DIP byte capture; addresses beyond the configured byte count are dropped.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dip_sw <= '0;
    end else begin
      for (int k = 0; k < DIP_BYTES; k++) begin
        if (dip_wr && addr_q[2:0] == 3'(k)) dip_sw[8*k +: 8] <= dout_q;
      end
    end
  end

  // rom_loaded latches when a ROM-index download window closes.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                                           rom_loaded <= 1'b0;
    else if (dl_qq && !dl_q && idx_lat == ROM_INDEX)     rom_loaded <= 1'b1;
  end

  // Core reset stretch counter; reloads while any hold source is active.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      count      <= HOLD_CYCLES;
      core_reset <= 1'b1;
    end else begin
      if (hold)               count <= HOLD_CYCLES;
      else if (count != 16'd0) count <= count - 16'd1;
      core_reset <= (count != 16'd0);
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  // Running byte sum, restarted when a ROM download begins.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rom_sum <= 16'd0;
    end else if (dl_q && !dl_qq && idx_q == ROM_INDEX) begin
      rom_sum <= 16'd0;
    end else if (state == ST_IDLE && accept) begin
      rom_sum <= rom_sum + {8'h00, dout_q};
    end
  end
`endif

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: scoreboard bench for rom_loader.
// Two instances share the HPS side: PORT_EN 2'b11 and PORT_EN 2'b01.
module tb_rom_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, soft_reset, dl, wr;
  logic [7:0]  idx, dout;
  logic [24:0] addr;
  logic [1:0]  ack0, ack1;

  logic        wait0, wait1, we0, we1, ld0, ld1, cr0, cr1, ov0, ov1;
  logic [1:0]  req0, req1, ds0, ds1;
  logic [22:0] a0, a1;
  logic [15:0] d0, d1;
  logic [63:0] dip0, dip1;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] sum0, sum1;
`endif

  rom_loader #(.NUM_PORTS(2), .PORT_EN(2'b11), .HOLD_CYCLES(16'd4)) u0 (
    .clk_sys(clk), .reset(reset), .soft_reset(soft_reset),
    .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wait0),
    .port_req(req0), .port_ack(ack0), .port_a(a0), .port_ds(ds0),
    .port_d(d0), .port_we(we0), .dip_sw(dip0), .rom_loaded(ld0),
    .core_reset(cr0),
`ifdef ROM_LOADER_CHECKSUM_EN
    .rom_sum(sum0),
`endif
    .overrun(ov0)
  );

  rom_loader #(.NUM_PORTS(2), .PORT_EN(2'b01), .HOLD_CYCLES(16'd4)) u1 (
    .clk_sys(clk), .reset(reset), .soft_reset(soft_reset),
    .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wait1),
    .port_req(req1), .port_ack(ack1), .port_a(a1), .port_ds(ds1),
    .port_d(d1), .port_we(we1), .dip_sw(dip1), .rom_loaded(ld1),
    .core_reset(cr1),
`ifdef ROM_LOADER_CHECKSUM_EN
    .rom_sum(sum1),
`endif
    .overrun(ov1)
  );

  typedef struct {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
    logic [1:0]  req;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [1:0] req_prev = 2'b00;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every port_req change on u0 must match the next queued issue.
  always @(negedge clk) begin
    if (!reset && req0 !== req_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_req", 64'(req0), 64'(req_prev));
      end else begin
        mon_e = sb.pop_front();
        check("sb_issue", {a0, ds0, d0, req0},
              {mon_e.a, mon_e.ds, mon_e.d, mon_e.req});
      end
    end
    req_prev = req0;
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(logic [24:0] ad, logic [7:0] dt);
    addr = ad;
    dout = dt;
    wr   = 1'b1;
    tick();
    wr   = 1'b0;
    tick();
  endtask

  task automatic ack_all();
    ack0    = req0;
    ack1[0] = req1[0];
  endtask

  task automatic wait_idle(string name);
    for (int k = 0; k < 50 && (wait0 || wait1); k++) tick();
    check(name, {wait0, wait1}, 2'b00);
  endtask

  task automatic push(logic [22:0] a, logic [1:0] ds, logic [15:0] d, logic [1:0] r);
    exp_t e;
    e.a = a; e.ds = ds; e.d = d; e.req = r;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1; soft_reset = 1'b0; dl = 1'b0; wr = 1'b0;
    idx = 8'd0; dout = 8'd0; addr = 25'd0; ack0 = 2'b00; ack1 = 2'b00;
    tick(3);
    check("rst_req", req0, 2'b00);
    check("rst_wait", wait0, 1'b0);
    check("rst_port", {a0, ds0, d0}, 0);
    check("rst_we", we0, 1'b0);
    check("rst_dip", dip0, 64'd0);
    check("rst_loaded", ld0, 1'b0);
    check("rst_overrun", ov0, 1'b0);
    check("rst_core_reset", cr0, 1'b1);

    reset = 1'b0;
    tick(20);
    check("no_load_core_reset", cr0, 1'b1);
    check("no_load_loaded", ld0, 1'b0);

    // DIP bytes
    dl = 1'b1; idx = 8'd254;
    tick();
    pulse(25'd1, 8'h3C);
    check("dip_no_wait", wait0, 1'b0);
    tick();
    check("dip_byte1", dip0[15:8], 8'h3C);
    pulse(25'd9, 8'h77);
    tick();
    check("dip_addr9_ignored", dip0, 64'h3C00);
    dl = 1'b0;
    tick(3);
    check("dip_not_loaded", ld0, 1'b0);

    // ROM download 1
    idx = 8'd0; dl = 1'b1;
    tick(2);
    push(23'h2, 2'b10, 16'hA5A5, 2'b11);
    addr = 25'd5; dout = 8'hA5; wr = 1'b1;
    tick();
    wr = 1'b0;
    check("issue_not_early", req0, 2'b00);
    check("wait_not_early", wait0, 1'b0);
    tick();
    check("issue_req1", req1, 2'b01);
    check("issue_wait0", wait0, 1'b1);
    check("issue_wait1", wait1, 1'b1);
    check("issue_we", we0, 1'b1);
    tick(2);
    ack0[0] = 1'b1;
    pulse(25'd6, 8'h11);
    check("overrun0", ov0, 1'b1);
    check("overrun1", ov1, 1'b1);
    check("wait_port0_only", wait0, 1'b1);
    check("no_extra_req1", req1, 2'b01);
    tick(2);
    ack0[1] = 1'b1;
    ack1[0] = 1'b1;
    tick();
    check("wait_ack_lag", wait0, 1'b1);
    tick();
    check("wait_done0", wait0, 1'b0);
    check("wait_done1", wait1, 1'b0);
    check("req1_bit1_held", req1, 2'b01);

    dl = 1'b0;
    for (k = 0; k < 10 && !ld0; k++) tick();
    check("rom_loaded_set", ld0, 1'b1);
`ifdef ROM_LOADER_CHECKSUM_EN
    check("sum_after_dl1", sum0, 16'h00A5);
`endif
    k = 0;
    while (cr0 && k < 20) begin tick(); k++; end
    check("core_reset_release", k, 5);

    // soft reset stretch
    soft_reset = 1'b1;
    tick(3);
    check("soft_core_reset", cr0, 1'b1);
    soft_reset = 1'b0;
    k = 0;
    while (cr0 && k < 20) begin tick(); k++; end
    check("soft_release", k, 5);

    // ROM download 2: checksum bytes, address boundary
    dl = 1'b1;
    tick(2);
    push(23'h8, 2'b01, 16'hFFFF, 2'b00);
    pulse(25'h10, 8'hFF);
    ack_all();
    wait_idle("idle_w2");
    push(23'h7FFFFF, 2'b10, 16'h0202, 2'b11);
    pulse(25'h0FFFFFF, 8'h02);
    ack_all();
    wait_idle("idle_w3");
    dl = 1'b0;
    tick(3);
    check("we_off", we0, 1'b0);
    check("overrun_sticky", ov0, 1'b1);
    check("loaded_sticky", ld0, 1'b1);
`ifdef ROM_LOADER_CHECKSUM_EN
    check("sum_ff_02", sum0, 16'h0101);
`endif

    // reset while BUSY
    dl = 1'b1;
    tick(2);
    push(23'h0, 2'b01, 16'h0000, 2'b00);
    pulse(25'd0, 8'h00);
    check("busy_before_rst", wait0, 1'b1);
    tick();
    reset = 1'b1;
    ack0 = 2'b00;
    ack1 = 2'b00;
    tick();
    check("midrst_req", req0, 2'b00);
    check("midrst_wait", wait0, 1'b0);
    check("midrst_flags", {ov0, ld0, cr0}, 3'b001);
    check("midrst_dip", dip0, 64'd0);
    dl = 1'b0;
    reset = 1'b0;
    tick(3);
    check("post_rst_req", req0, 2'b00);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
